pc_seq: RTL and testbench

- Program-counter sequencer that sits directly upstream of the subroutine return-address stack.
- Generates the fetch/execute phase signal `ck2` consumed by the stack.
- Drives the return address `one_addr` to the stack.
- Selects the next PC from sequential, jump-target or stack-top (`stack_d`) sources according to the decoded instruction `kind`.

---
 rtl/pc_seq.sv | 104 ++++++++++
 tb/tb_pc_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - program-counter sequencer driving the return-address stack
// Two-phase FETCH/EXEC sequencer; stack errors and HLT park it in HALT until reset.
module pc_seq #(
    parameter int             AW       = 12,
    parameter logic [AW-1:0]  RESET_PC = '0,
    parameter int             DEPTH    = 4
) (
    input  logic          ck,
    input  logic          res,
    input  logic [3:0]    kind,
    input  logic [AW-1:0] target,
    input  logic          zflag,
    input  logic [AW-1:0] stack_d,
    input  logic [2:0]    sp,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] one_addr,
    output logic          ck2,
    output logic          halted,
    output logic [1:0]    err
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam logic [3:0] K_BZ  = 4'b0100;
    localparam logic [3:0] K_JMP = 4'b0101;
    localparam logic [3:0] K_JSB = 4'b0110;
    localparam logic [3:0] K_RET = 4'b0111;
    localparam logic [3:0] K_HLT = 4'b1111;
    localparam logic [3:0] DEPTH_L = 4'(DEPTH);

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [1:0]    err_q, err_d;
    logic          ck2_q;
    logic [AW-1:0] pc_inc;
    logic          stack_full, stack_empty;

    assign pc_inc      = pc_q + AW'(1);
    assign stack_full  = {1'b0, sp} >= DEPTH_L;
    assign stack_empty = (sp == 3'd0);

    always_ff @(posedge ck or posedge res) begin
        if (res) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            err_q   <= 2'b00;
            ck2_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
            ck2_q   <= (state_d == S_FETCH);
        end
    end

    // Error checks come first so a faulting JSB/RET never touches pc.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = err_q;
        case (state_q)
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                state_d = S_FETCH;
                case (kind)
                    K_JMP: pc_d = target;
                    K_BZ:  pc_d = zflag ? target : pc_inc;
                    K_JSB: begin
                        if (stack_full) begin
                            err_d[0] = 1'b1;
                            state_d  = S_HALT;
                        end else begin
                            pc_d = target;
                        end
                    end
                    K_RET: begin
                        if (stack_empty) begin
                            err_d[1] = 1'b1;
                            state_d  = S_HALT;
                        end else begin
                            pc_d = stack_d;
                        end
                    end
                    K_HLT:   state_d = S_HALT;
                    default: pc_d = pc_inc;
                endcase
            end
            default: state_d = S_HALT;
        endcase
    end

    always_comb begin
        pc       = pc_q;
        one_addr = pc_inc;
        ck2      = ck2_q;
        halted   = (state_q == S_HALT);
        err      = err_q;
    end

endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - scoreboard testbench for pc_seq
module tb_pc_seq;

    logic        ck = 1'b0;
    logic        res;
    logic [3:0]  kind;
    logic [11:0] target;
    logic        zflag;
    logic [11:0] stack_d;
    logic [2:0]  sp;
    logic [11:0] pc;
    logic [11:0] one_addr;
    logic        ck2;
    logic        halted;
    logic [1:0]  err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [11:0] pc;
        logic        halted;
        logic [1:0]  err;
    } exp_t;

    exp_t sb_q[$];

    logic [11:0] m_pc;
    logic        m_halt;
    logic [1:0]  m_err;

    pc_seq #(.AW(12), .RESET_PC(12'h000), .DEPTH(4)) dut (
        .ck(ck), .res(res), .kind(kind), .target(target), .zflag(zflag),
        .stack_d(stack_d), .sp(sp), .pc(pc), .one_addr(one_addr),
        .ck2(ck2), .halted(halted), .err(err)
    );

    always #5 ck = ~ck;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge ck);
        res = 1'b1;
        #1;
        check("rst_pc", pc, 12'h000);
        check("rst_ck2", ck2, 1'b1);
        check("rst_halted", halted, 1'b0);
        check("rst_err", err, 2'b00);
        @(negedge ck);
        res    = 1'b0;
        m_pc   = 12'h000;
        m_halt = 1'b0;
        m_err  = 2'b00;
    endtask

    // Called at a negedge while in FETCH; leaves the bench at the negedge after EXEC.
    task automatic exec(input string tag, input logic [3:0] k, input logic [11:0] t,
                        input logic z, input logic [11:0] sd, input logic [2:0] s);
        exp_t e;
        exp_t got;
        logic [11:0] ret_addr;
        kind = k; target = t; zflag = z; stack_d = sd; sp = s;
        ret_addr = m_pc + 12'd1;
        case (k)
            4'b0101: m_pc = t;
            4'b0100: m_pc = z ? t : m_pc + 12'd1;
            4'b0110: if (s >= 3'd4) begin m_err[0] = 1'b1; m_halt = 1'b1; end else m_pc = t;
            4'b0111: if (s == 3'd0) begin m_err[1] = 1'b1; m_halt = 1'b1; end else m_pc = sd;
            4'b1111: m_halt = 1'b1;
            default: m_pc = m_pc + 12'd1;
        endcase
        e.pc = m_pc; e.halted = m_halt; e.err = m_err;
        sb_q.push_back(e);
        @(negedge ck);
        check({tag, "_exec_ck2"}, ck2, 1'b0);
        check({tag, "_one_addr"}, one_addr, ret_addr);
        @(negedge ck);
        kind = 4'b0000;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            got = sb_q.pop_front();
            check({tag, "_pc"}, pc, got.pc);
            check({tag, "_halted"}, halted, got.halted);
            check({tag, "_err"}, err, got.err);
            check({tag, "_ck2"}, ck2, !got.halted);
        end
    endtask

    task automatic idle_halted(input string tag, input logic [11:0] pc_exp, input logic [1:0] err_exp);
        for (int i = 0; i < 3; i++) begin
            @(negedge ck);
            check({tag, "_hold_pc"}, pc, pc_exp);
            check({tag, "_hold_halted"}, halted, 1'b1);
            check({tag, "_hold_ck2"}, ck2, 1'b0);
            check({tag, "_hold_err"}, err, err_exp);
        end
    endtask

    logic [11:0] free_pc [8];
    logic        free_ck2 [8];

    initial begin
        res = 1'b1; kind = 4'b0000; target = '0; zflag = 1'b0; stack_d = '0; sp = '0;
        m_pc = '0; m_halt = 1'b0; m_err = 2'b00;
        free_pc  = '{12'h000, 12'h000, 12'h001, 12'h001, 12'h002, 12'h002, 12'h003, 12'h003};
        free_ck2 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        #2;
        check("por_pc", pc, 12'h000);
        check("por_ck2", ck2, 1'b1);
        check("por_halted", halted, 1'b0);
        check("por_err", err, 2'b00);
        @(negedge ck);
        res = 1'b0;

        for (int i = 0; i < 8; i++) begin
            check($sformatf("free_pc%0d", i), pc, free_pc[i]);
            check($sformatf("free_ck2_%0d", i), ck2, free_ck2[i]);
            check($sformatf("free_halted%0d", i), halted, 1'b0);
            @(negedge ck);
        end
        m_pc = 12'h004;

        exec("jmp_ffe", 4'b0101, 12'hFFE, 1'b0, 12'h000, 3'd0);
        exec("nop_fff", 4'b0000, 12'h000, 1'b0, 12'h000, 3'd0);
        check("wrap_one_addr", one_addr, 12'h000);
        exec("nop_wrap", 4'b0000, 12'h000, 1'b0, 12'h000, 3'd0);

        exec("jmp_010", 4'b0101, 12'h010, 1'b0, 12'h000, 3'd0);
        exec("jsb_200", 4'b0110, 12'h200, 1'b0, 12'hABC, 3'd0);
        exec("nop_201", 4'b0011, 12'h000, 1'b0, 12'h000, 3'd1);
        exec("ret_011", 4'b0111, 12'h555, 1'b0, 12'h011, 3'd1);

        exec("jmp_020a", 4'b0101, 12'h020, 1'b0, 12'h000, 3'd0);
        exec("bz_taken", 4'b0100, 12'h080, 1'b1, 12'h000, 3'd0);
        exec("jmp_020b", 4'b0101, 12'h020, 1'b0, 12'h000, 3'd0);
        exec("bz_not", 4'b0100, 12'h080, 1'b0, 12'h000, 3'd0);

        exec("jsb_ovf", 4'b0110, 12'h300, 1'b0, 12'h000, 3'd4);
        idle_halted("ovf", 12'h021, 2'b01);

        do_reset();
        exec("ret_unf", 4'b0111, 12'h300, 1'b0, 12'h7AA, 3'd0);
        idle_halted("unf", 12'h000, 2'b10);

        do_reset();
        exec("pre_hlt", 4'b1010, 12'h000, 1'b0, 12'h000, 3'd0);
        exec("hlt", 4'b1111, 12'h400, 1'b0, 12'h000, 3'd0);
        idle_halted("hlt", 12'h001, 2'b00);

        do_reset();
        exec("pre_mid", 4'b0000, 12'h000, 1'b0, 12'h000, 3'd0);
        kind = 4'b0101; target = 12'h300;
        @(posedge ck);
        #2;
        check("mid_state_ck2", ck2, 1'b0);
        res = 1'b1;
        #1;
        check("mid_rst_pc", pc, 12'h000);
        check("mid_rst_ck2", ck2, 1'b1);
        @(negedge ck);
        res = 1'b0; kind = 4'b0000;
        m_pc = 12'h000; m_halt = 1'b0; m_err = 2'b00;
        check("mid_release_pc", pc, 12'h000);
        exec("post_mid", 4'b0000, 12'h000, 1'b0, 12'h000, 3'd0);

        check("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
